// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the instruction/data bus arbiter.
//   DATA_W / RegBus : address and data bus width
//   IF_SEL          : byte enables driven for instruction fetches
//   state_e         : arbiter FSM encoding
//   grant_e         : which port owned the last bus grant
package bus_arbiter_pkg;
  localparam int DATA_W = 32;
  localparam int RegBus = DATA_W;

  localparam logic [3:0] IF_SEL = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUS_IF  = 2'd1,
    ST_BUS_MEM = 2'd2,
    ST_DRAIN   = 2'd3
  } state_e;

  typedef enum logic {
    GNT_IF  = 1'b0,
    GNT_MEM = 1'b1
  } grant_e;
endpackage

// File: rtl/bus_arbiter_if.sv
// Signal bundle between the pipeline ports, the shared bus and the arbiter.
// Names carry the arbiter's point of view (_i into it, _o out of it).
//   slave  : arbiter side
//   master : pipeline / bus model side
interface bus_arbiter_if #(
  parameter int DATA_W = bus_arbiter_pkg::DATA_W
);
  // instruction-fetch port
  logic              if_req_i;
  logic [DATA_W-1:0] if_addr_i;
  logic [DATA_W-1:0] if_data_o;
  logic              if_ack_o;
  // data port
  logic              mem_req_i;
  logic              mem_we_i;
  logic [3:0]        mem_sel_i;
  logic [DATA_W-1:0] mem_addr_i;
  logic [DATA_W-1:0] mem_data_i;
  logic [DATA_W-1:0] mem_data_o;
  logic              mem_ack_o;
  // pipeline control
  logic              flush_i;
  logic              stallreq_if_o;
  logic              stallreq_mem_o;
  // shared bus
  logic              bus_stb_o;
  logic              bus_we_o;
  logic [3:0]        bus_sel_o;
  logic [DATA_W-1:0] bus_addr_o;
  logic [DATA_W-1:0] bus_data_o;
  logic [DATA_W-1:0] bus_data_i;
  logic              bus_ack_i;

  modport slave (
    input  if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_sel_i, mem_addr_i,
           mem_data_i, flush_i, bus_data_i, bus_ack_i,
    output if_data_o, if_ack_o, mem_data_o, mem_ack_o, stallreq_if_o,
           stallreq_mem_o, bus_stb_o, bus_we_o, bus_sel_o, bus_addr_o, bus_data_o
  );

  modport master (
    output if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_sel_i, mem_addr_i,
           mem_data_i, flush_i, bus_data_i, bus_ack_i,
    input  if_data_o, if_ack_o, mem_data_o, mem_ack_o, stallreq_if_o,
           stallreq_mem_o, bus_stb_o, bus_we_o, bus_sel_o, bus_addr_o, bus_data_o
  );
endinterface

// File: rtl/bus_arbiter.sv
// Two-port (fetch / data) arbiter onto one shared single-outstanding bus.
// Round-robin on ties, one dead cycle between transactions, fetch
// cancellable by flush (DRAIN finishes the bus cycle silently).
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : bus_arbiter_if.slave (ports, shared bus, stall requests)
module bus_arbiter #(
  parameter int DATA_W = bus_arbiter_pkg::DATA_W
) (
  input logic         clk,
  input logic         rst,
  bus_arbiter_if.slave bus
);
  import bus_arbiter_pkg::*;

  state_e            state_q, state_d;
  grant_e            last_q, last_d;
  logic              stb_q, stb_d, we_q, we_d;
  logic [3:0]        sel_q, sel_d;
  logic [DATA_W-1:0] addr_q, addr_d, wdat_q, wdat_d;
  logic [DATA_W-1:0] if_dat_q, if_dat_d, mem_dat_q, mem_dat_d;
  logic              if_ack_q, if_ack_d, mem_ack_q, mem_ack_d;
  logic              if_elig, mem_elig, pick_mem, pick_if;

  // A port whose ack is showing this cycle has just been served; the
  // master has not yet had a chance to drop or renew its request.
  assign if_elig  = bus.if_req_i & ~if_ack_q & ~bus.flush_i;
  assign mem_elig = bus.mem_req_i & ~mem_ack_q;
  assign pick_mem = mem_elig & (~if_elig | (last_q == GNT_IF));
  assign pick_if  = if_elig & ~pick_mem;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    stb_d     = stb_q;
    we_d      = we_q;
    sel_d     = sel_q;
    addr_d    = addr_q;
    wdat_d    = wdat_q;
    if_dat_d  = if_dat_q;
    mem_dat_d = mem_dat_q;
    if_ack_d  = 1'b0;
    mem_ack_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_mem) begin
          state_d = ST_BUS_MEM;
          last_d  = GNT_MEM;
          stb_d   = 1'b1;
          we_d    = bus.mem_we_i;
          sel_d   = bus.mem_sel_i;
          addr_d  = bus.mem_addr_i;
          wdat_d  = bus.mem_data_i;
        end else if (pick_if) begin
          state_d = ST_BUS_IF;
          last_d  = GNT_IF;
          stb_d   = 1'b1;
          we_d    = 1'b0;
          sel_d   = IF_SEL;
          addr_d  = bus.if_addr_i;
          wdat_d  = '0;
        end
      end
      ST_BUS_IF: begin
        if (bus.flush_i) begin
          // Fetch is dead: finish the bus cycle but never report it.
          if (bus.bus_ack_i) begin
            state_d = ST_IDLE;
            stb_d   = 1'b0;
          end else begin
            state_d = ST_DRAIN;
          end
        end else if (bus.bus_ack_i) begin
          state_d  = ST_IDLE;
          stb_d    = 1'b0;
          if_dat_d = bus.bus_data_i;
          if_ack_d = 1'b1;
        end
      end
      ST_BUS_MEM: begin
        if (bus.bus_ack_i) begin
          state_d   = ST_IDLE;
          stb_d     = 1'b0;
          mem_ack_d = 1'b1;
          if (!we_q) mem_dat_d = bus.bus_data_i;
        end
      end
      ST_DRAIN: begin
        if (bus.bus_ack_i) begin
          state_d = ST_IDLE;
          stb_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      last_q    <= GNT_IF;
      stb_q     <= 1'b0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      addr_q    <= '0;
      wdat_q    <= '0;
      if_dat_q  <= '0;
      mem_dat_q <= '0;
      if_ack_q  <= 1'b0;
      mem_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      stb_q     <= stb_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      addr_q    <= addr_d;
      wdat_q    <= wdat_d;
      if_dat_q  <= if_dat_d;
      mem_dat_q <= mem_dat_d;
      if_ack_q  <= if_ack_d;
      mem_ack_q <= mem_ack_d;
    end
  end

  assign bus.bus_stb_o      = stb_q;
  assign bus.bus_we_o       = we_q;
  assign bus.bus_sel_o      = sel_q;
  assign bus.bus_addr_o     = addr_q;
  assign bus.bus_data_o     = wdat_q;
  assign bus.if_data_o      = if_dat_q;
  assign bus.if_ack_o       = if_ack_q;
  assign bus.mem_data_o     = mem_dat_q;
  assign bus.mem_ack_o      = mem_ack_q;
  assign bus.stallreq_if_o  = bus.if_req_i & ~if_ack_q & ~bus.flush_i;
  assign bus.stallreq_mem_o = bus.mem_req_i & ~mem_ack_q;
endmodule
